// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle RISC-V controller and its datapath.
// The controller drives the enables, mux selects and ALU operation; the datapath supplies instruction fields and zero.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       illegalOp;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7b5, zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegalOp, state
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegalOp, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RISC-V datapath with an embedded ALU decoder.
// State-derived controls are registered alongside the state so they change cleanly on the clock edge.
module multicycle_controller #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master ctrl
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctl_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t state_q;
  ctl_t   ctl_q;
  logic   op_known;

  function automatic logic is_known(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
           (o == OP_BEQ) || (o == OP_JAL);
  endfunction

  function automatic state_t next_of(input state_t s, input logic [6:0] o);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:    n = S_DECODE;
      S_DECODE: begin
        if (o == OP_LW || o == OP_SW) n = S_MEMADR;
        else if (o == OP_R)           n = S_EXECUTER;
        else if (o == OP_I)           n = S_EXECUTEI;
        else if (o == OP_BEQ)         n = S_BEQ;
        else if (o == OP_JAL)         n = S_JAL;
        else                          n = ILLEGAL_HALT ? S_HALT : S_FETCH;
      end
      S_MEMADR:   n = (o == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  n = S_MEMWB;
      S_EXECUTER: n = S_ALUWB;
      S_EXECUTEI: n = S_ALUWB;
      S_JAL:      n = S_ALUWB;
      S_HALT:     n = S_HALT;
      default:    n = S_FETCH;
    endcase
    return n;
  endfunction

  // Control word asserted while sitting in a given state; anything not named stays 0.
  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; c.pc_update = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
      end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01; c.reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src = 1'b1; c.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = 2'b10; c.alu_op = 2'b10;
      end
      S_EXECUTEI: begin
        c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10;
      end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BEQ: begin
        c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctl_q   <= ctl_of(S_FETCH);
    end else begin
      state_q <= next_of(state_q, ctrl.op);
      ctl_q   <= ctl_of(next_of(state_q, ctrl.op));
    end
  end

  // ALU decoder: only ALUOp 10 consults the funct fields; op[5] separates sub from addi with instr[30] set.
  always_comb begin
    ctrl.ALUControl = 3'b000;
    case (ctl_q.alu_op)
      2'b01: ctrl.ALUControl = 3'b001;
      2'b10: begin
        case (ctrl.funct3)
          3'b000:  ctrl.ALUControl = (ctrl.op[5] & ctrl.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ctrl.ALUControl = 3'b101;
          3'b110:  ctrl.ALUControl = 3'b011;
          3'b111:  ctrl.ALUControl = 3'b010;
          default: ctrl.ALUControl = 3'b000;
        endcase
      end
      default: ctrl.ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ctrl.ImmSrc = 2'b00;
    case (ctrl.op)
      OP_SW:   ctrl.ImmSrc = 2'b01;
      OP_BEQ:  ctrl.ImmSrc = 2'b10;
      OP_JAL:  ctrl.ImmSrc = 2'b11;
      default: ctrl.ImmSrc = 2'b00;
    endcase
  end

  assign op_known = is_known(ctrl.op);

  // Write enables are gated by reset so an interrupted instruction cannot commit anything.
  assign ctrl.PCWrite   = (ctl_q.pc_update | (ctl_q.branch & ctrl.zero)) & ~reset;
  assign ctrl.IRWrite   = ctl_q.ir_write & ~reset;
  assign ctrl.MemWrite  = ctl_q.mem_write & ~reset;
  assign ctrl.RegWrite  = ctl_q.reg_write & ~reset;
  assign ctrl.AdrSrc    = ctl_q.adr_src;
  assign ctrl.ResultSrc = ctl_q.result_src;
  assign ctrl.ALUSrcA   = ctl_q.alu_src_a;
  assign ctrl.ALUSrcB   = ctl_q.alu_src_b;
  assign ctrl.illegalOp = (state_q == S_HALT) || ((state_q == S_DECODE) && !op_known);
  assign ctrl.state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through its states
// and checks controls against hand-derived values; a second instance covers the halting mode.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  int         compared;
  int         mismatched;

  multicycle_controller_if bus0 ();
  multicycle_controller_if bus1 ();

  assign bus0.op = op;       assign bus1.op = op;
  assign bus0.funct3 = funct3;   assign bus1.funct3 = funct3;
  assign bus0.funct7b5 = funct7b5; assign bus1.funct7b5 = funct7b5;
  assign bus0.zero = zero;     assign bus1.zero = zero;

  multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut0 (.clk(clk), .reset(reset), .ctrl(bus0));
  multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut1 (.clk(clk), .reset(reset), .ctrl(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    reset = 1'b1;
    applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b0);

    tick(); tick();
    checkOutput("rst_state", 32'(bus0.state), 32'd0);
    checkOutput("rst_pcwrite", 32'(bus0.PCWrite), 32'd0);
    checkOutput("rst_irwrite", 32'(bus0.IRWrite), 32'd0);
    checkOutput("rst_memwrite", 32'(bus0.MemWrite), 32'd0);
    checkOutput("rst_regwrite", 32'(bus0.RegWrite), 32'd0);

    reset = 1'b0; #1;
    checkOutput("fetch_irwrite", 32'(bus0.IRWrite), 32'd1);
    checkOutput("fetch_pcwrite", 32'(bus0.PCWrite), 32'd1);
    checkOutput("fetch_aluctl", 32'(bus0.ALUControl), 32'd0);
    checkOutput("fetch_srcb", 32'(bus0.ALUSrcB), 32'd2);
    checkOutput("fetch_ressrc", 32'(bus0.ResultSrc), 32'd2);

    // sub
    applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0);
    tick();
    checkOutput("sub_s1", 32'(bus0.state), 32'd1);
    checkOutput("sub_dec_srca", 32'(bus0.ALUSrcA), 32'd1);
    checkOutput("sub_dec_srcb", 32'(bus0.ALUSrcB), 32'd1);
    checkOutput("sub_dec_aluctl", 32'(bus0.ALUControl), 32'd0);
    checkOutput("sub_dec_irwrite", 32'(bus0.IRWrite), 32'd0);
    checkOutput("sub_dec_illegal", 32'(bus0.illegalOp), 32'd0);
    tick();
    checkOutput("sub_s6", 32'(bus0.state), 32'd6);
    checkOutput("sub_ex_aluctl", 32'(bus0.ALUControl), 32'd1);
    checkOutput("sub_ex_regwrite", 32'(bus0.RegWrite), 32'd0);
    checkOutput("sub_ex_srca", 32'(bus0.ALUSrcA), 32'd2);
    checkOutput("sub_ex_srcb", 32'(bus0.ALUSrcB), 32'd0);
    funct3 = 3'b110; #1;
    checkOutput("or_ex_aluctl", 32'(bus0.ALUControl), 32'd3);
    funct3 = 3'b111; #1;
    checkOutput("and_ex_aluctl", 32'(bus0.ALUControl), 32'd2);
    tick();
    checkOutput("sub_s8", 32'(bus0.state), 32'd8);
    checkOutput("sub_wb_regwrite", 32'(bus0.RegWrite), 32'd1);
    checkOutput("sub_wb_ressrc", 32'(bus0.ResultSrc), 32'd0);
    tick();
    checkOutput("sub_s0", 32'(bus0.state), 32'd0);

    // lw
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0);
    tick();
    checkOutput("lw_s1", 32'(bus0.state), 32'd1);
    checkOutput("lw_immsrc", 32'(bus0.ImmSrc), 32'd0);
    tick();
    checkOutput("lw_s2", 32'(bus0.state), 32'd2);
    checkOutput("lw_adr_aluctl", 32'(bus0.ALUControl), 32'd0);
    tick();
    checkOutput("lw_s3", 32'(bus0.state), 32'd3);
    checkOutput("lw_rd_adrsrc", 32'(bus0.AdrSrc), 32'd1);
    tick();
    checkOutput("lw_s4", 32'(bus0.state), 32'd4);
    checkOutput("lw_wb_ressrc", 32'(bus0.ResultSrc), 32'd1);
    checkOutput("lw_wb_regwrite", 32'(bus0.RegWrite), 32'd1);
    tick();
    checkOutput("lw_s0", 32'(bus0.state), 32'd0);

    // sw
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0);
    tick();
    checkOutput("sw_immsrc", 32'(bus0.ImmSrc), 32'd1);
    tick();
    checkOutput("sw_s2_memwrite", 32'(bus0.MemWrite), 32'd0);
    tick();
    checkOutput("sw_s5", 32'(bus0.state), 32'd5);
    checkOutput("sw_memwrite", 32'(bus0.MemWrite), 32'd1);
    checkOutput("sw_adrsrc", 32'(bus0.AdrSrc), 32'd1);
    tick();
    checkOutput("sw_s0", 32'(bus0.state), 32'd0);
    checkOutput("sw_fetch_memwrite", 32'(bus0.MemWrite), 32'd0);

    // beq
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1);
    tick();
    checkOutput("beq_immsrc", 32'(bus0.ImmSrc), 32'd2);
    checkOutput("beq_dec_pcwrite", 32'(bus0.PCWrite), 32'd0);
    tick();
    checkOutput("beq_s9", 32'(bus0.state), 32'd9);
    checkOutput("beq_taken_pcwrite", 32'(bus0.PCWrite), 32'd1);
    checkOutput("beq_aluctl", 32'(bus0.ALUControl), 32'd1);
    zero = 1'b0; #1;
    checkOutput("beq_nt_pcwrite", 32'(bus0.PCWrite), 32'd0);
    tick();
    checkOutput("beq_s0", 32'(bus0.state), 32'd0);

    // jal
    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0);
    tick();
    checkOutput("jal_immsrc", 32'(bus0.ImmSrc), 32'd3);
    tick();
    checkOutput("jal_s10", 32'(bus0.state), 32'd10);
    checkOutput("jal_pcwrite", 32'(bus0.PCWrite), 32'd1);
    checkOutput("jal_srca", 32'(bus0.ALUSrcA), 32'd1);
    checkOutput("jal_srcb", 32'(bus0.ALUSrcB), 32'd2);
    tick();
    checkOutput("jal_s8", 32'(bus0.state), 32'd8);
    tick();
    checkOutput("jal_s0", 32'(bus0.state), 32'd0);

    // slti, then addi with instr[30] set must still add
    applyStimulus(7'b0010011, 3'b010, 1'b0, 1'b0);
    tick(); tick();
    checkOutput("slti_s7", 32'(bus0.state), 32'd7);
    checkOutput("slti_aluctl", 32'(bus0.ALUControl), 32'd5);
    checkOutput("slti_srcb", 32'(bus0.ALUSrcB), 32'd1);
    funct3 = 3'b000; funct7b5 = 1'b1; #1;
    checkOutput("addi_aluctl", 32'(bus0.ALUControl), 32'd0);
    tick(); tick();
    checkOutput("addi_s0", 32'(bus0.state), 32'd0);

    // unknown opcode in both modes
    applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b0);
    tick();
    checkOutput("ill0_dec", 32'(bus0.illegalOp), 32'd1);
    checkOutput("ill1_dec", 32'(bus1.illegalOp), 32'd1);
    tick();
    checkOutput("ill0_s0", 32'(bus0.state), 32'd0);
    checkOutput("ill0_cleared", 32'(bus0.illegalOp), 32'd0);
    checkOutput("ill1_s11", 32'(bus1.state), 32'd11);
    checkOutput("ill1_flag", 32'(bus1.illegalOp), 32'd1);
    checkOutput("ill1_pcwrite", 32'(bus1.PCWrite), 32'd0);
    checkOutput("ill1_irwrite", 32'(bus1.IRWrite), 32'd0);
    applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b1);
    tick(); tick(); tick();
    checkOutput("ill1_held", 32'(bus1.state), 32'd11);
    checkOutput("ill1_regwrite", 32'(bus1.RegWrite), 32'd0);

    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    checkOutput("halt_rst_s0", 32'(bus1.state), 32'd0);
    checkOutput("halt_rst_illegal", 32'(bus1.illegalOp), 32'd0);

    // reset during MEMWRITE
    applyStimulus(7'b0100011, 3'b000, 1'b0, 1'b0);
    tick(); tick(); tick();
    checkOutput("rsw_memwrite", 32'(bus0.MemWrite), 32'd1);
    reset = 1'b1; #1;
    checkOutput("rsw_memwrite_gated", 32'(bus0.MemWrite), 32'd0);
    tick();
    checkOutput("rsw_s0", 32'(bus0.state), 32'd0);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
